// File: rtl/ps2_move_decoder_if.sv
// PS/2 line inputs and decoded move/byte outputs for ps2_move_decoder.
// master = keyboard/stimulus side, slave = the decoder.
interface ps2_move_decoder_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [3:0] key_pressed;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  key_pressed, byte_valid, rx_byte, frame_err
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output key_pressed, byte_valid, rx_byte, frame_err
  );
endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard receiver plus scan-code decoder producing one-cycle move pulses.
// byte_valid/frame_err one cycle after the stop edge, key_pressed one cycle later; never stalls.
module ps2_move_decoder #(
  parameter int TIMEOUT = 50000
) (
  input  logic              CLOCK_50,
  input  logic              rstn,
  ps2_move_decoder_if.slave ps2
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state_q;
  logic            clk_s1_q, clk_s2_q, clk_prev_q;
  logic            dat_s1_q, dat_s2_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [TW-1:0]   to_cnt_q;
  logic            byte_valid_q;
  logic            frame_err_q;
  logic [7:0]      rx_byte_q;

  logic            brk_q, ext_q;
  logic [3:0]      held_q;
  logic [3:0]      key_pressed_q;

  logic            fall;
  logic            map_hit_d;
  logic [1:0]      map_idx_d;

  // Synchronizers idle high so reset never looks like a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2.PS2_CLK;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2.PS2_DAT;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_byte_q    <= 8'h00;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        to_cnt_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            // Odd parity: data plus parity bit must hold an odd count of ones.
            if (dat_s2_q && (^{shift_q, par_q})) begin
              byte_valid_q <= 1'b1;
              rx_byte_q    <= shift_q;
            end else begin
              frame_err_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (to_cnt_q == TO_LAST) begin
          frame_err_q <= 1'b1;
          state_q     <= IDLE;
          to_cnt_q    <= '0;
          bit_cnt_q   <= 3'd0;
          shift_q     <= 8'h00;
        end else begin
          to_cnt_q    <= to_cnt_q + 1'b1;
        end
      end
    end
  end

  // Letter keys and arrow keys land on the same move bit.
  always_comb begin
    map_hit_d = 1'b0;
    map_idx_d = 2'd0;
    if (!ext_q) begin
      case (rx_byte_q)
        8'h1D:   begin map_hit_d = 1'b1; map_idx_d = 2'd1; end
        8'h1B:   begin map_hit_d = 1'b1; map_idx_d = 2'd0; end
        8'h1C:   begin map_hit_d = 1'b1; map_idx_d = 2'd3; end
        8'h23:   begin map_hit_d = 1'b1; map_idx_d = 2'd2; end
        default: ;
      endcase
    end else begin
      case (rx_byte_q)
        8'h75:   begin map_hit_d = 1'b1; map_idx_d = 2'd1; end
        8'h72:   begin map_hit_d = 1'b1; map_idx_d = 2'd0; end
        8'h6B:   begin map_hit_d = 1'b1; map_idx_d = 2'd3; end
        8'h74:   begin map_hit_d = 1'b1; map_idx_d = 2'd2; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      held_q        <= 4'b0000;
      key_pressed_q <= 4'b0000;
    end else begin
      key_pressed_q <= 4'b0000;
      if (byte_valid_q) begin
        if (rx_byte_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (rx_byte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (map_hit_d) begin
            if (brk_q) begin
              held_q[map_idx_d] <= 1'b0;
            end else if (!held_q[map_idx_d]) begin
              held_q[map_idx_d] <= 1'b1;
              key_pressed_q     <= 4'b0001 << map_idx_d;
            end
          end
        end
      end
    end
  end

  assign ps2.key_pressed = key_pressed_q;
  assign ps2.byte_valid  = byte_valid_q;
  assign ps2.rx_byte     = rx_byte_q;
  assign ps2.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed PS/2 frames with a scoreboard of expected pulses checked by a separate monitor.
// Each expected event carries the exact CLOCK_50 cycle at which it must appear.
module tb_ps2_move_decoder;

  localparam int TO = 300;
  localparam int H  = 10;
  localparam int K_BV  = 0;
  localparam int K_ERR = 1;
  localparam int K_KEY = 2;

  typedef struct {
    int         kind;
    logic [7:0] val;
    int         cyc;
  } ev_t;

  logic CLOCK_50 = 1'b0;
  logic rstn     = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_fall = 0;
  logic [7:0] last_rx = 8'h00;
  ev_t  expq[$];

  ps2_move_decoder_if bus ();

  ps2_move_decoder #(.TIMEOUT(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .rstn     (rstn),
    .ps2      (bus.slave)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc = cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input int kind, input logic [7:0] val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    expq.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [7:0] val);
    ev_t e;
    n_checks++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d val=%02h at cycle %0d, scoreboard empty", kind, val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind=%0d val=%02h cycle=%0d, expected kind=%0d val=%02h cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (bus.byte_valid) check_ev(K_BV, bus.rx_byte);
    if (bus.frame_err)  check_ev(K_ERR, bus.rx_byte);
    if (bus.key_pressed != 4'b0000) begin
      n_checks++;
      if ($countones(bus.key_pressed) != 1) begin
        n_fail++;
        $display("FAIL onehot: key_pressed=%b not one-hot at cycle %0d", bus.key_pressed, cyc);
      end
      check_ev(K_KEY, {4'b0000, bus.key_pressed});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Sends the first nfalls bits of a frame; a complete frame schedules its expected events.
  task automatic send(input logic [7:0] b, input bit flip, input int nfalls, input logic [3:0] key);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      bus.PS2_DAT = bits[i];
      tick(H);
      bus.PS2_CLK = 1'b0;
      last_fall = cyc;
      if (i == 10) begin
        if (!flip) begin
          push(K_BV, b, cyc + 3);
          if (key != 4'b0000) push(K_KEY, {4'b0000, key}, cyc + 4);
          last_rx = b;
        end else begin
          push(K_ERR, last_rx, cyc + 3);
        end
      end
      tick(H);
      bus.PS2_CLK = 1'b1;
    end
    bus.PS2_DAT = 1'b1;
    tick(H);
  endtask

  initial begin
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    rstn = 1'b0;
    tick(5);
    chk("reset_key_pressed", {4'b0000, bus.key_pressed}, 8'h00);
    chk("reset_byte_valid", {7'b0, bus.byte_valid}, 8'h00);
    chk("reset_frame_err", {7'b0, bus.frame_err}, 8'h00);
    chk("reset_rx_byte", bus.rx_byte, 8'h00);
    rstn = 1'b1;
    tick(5);

    send(8'h1D, 0, 11, 4'b0010);
    send(8'h1D, 0, 11, 4'b0000);
    send(8'h1D, 0, 11, 4'b0000);
    send(8'hF0, 0, 11, 4'b0000);
    send(8'h1D, 0, 11, 4'b0000);
    send(8'h1D, 0, 11, 4'b0010);

    send(8'hE0, 0, 11, 4'b0000);
    send(8'h6B, 0, 11, 4'b1000);
    send(8'hE0, 0, 11, 4'b0000);
    send(8'hF0, 0, 11, 4'b0000);
    send(8'h6B, 0, 11, 4'b0000);
    send(8'h1C, 0, 11, 4'b1000);

    send(8'hF0, 0, 11, 4'b0000);
    send(8'h1D, 0, 11, 4'b0000);
    send(8'hE0, 0, 11, 4'b0000);
    send(8'h1D, 0, 11, 4'b0000);
    send(8'h1D, 0, 11, 4'b0010);
    send(8'hE0, 0, 11, 4'b0000);
    send(8'h75, 0, 11, 4'b0000);
    send(8'h77, 0, 11, 4'b0000);

    send(8'h23, 1, 11, 4'b0000);
    tick(10);

    // Start bit plus four data bits, then the line goes quiet.
    send(8'h5A, 0, 5, 4'b0000);
    push(K_ERR, last_rx, last_fall + 3 + TO);
    tick(TO + 20);
    send(8'h1B, 0, 11, 4'b0001);

    send(8'h1C, 0, 6, 4'b0000);
    rstn = 1'b0;
    tick(3);
    chk("midreset_key_pressed", {4'b0000, bus.key_pressed}, 8'h00);
    chk("midreset_byte_valid", {7'b0, bus.byte_valid}, 8'h00);
    chk("midreset_frame_err", {7'b0, bus.frame_err}, 8'h00);
    chk("midreset_rx_byte", bus.rx_byte, 8'h00);
    last_rx = 8'h00;
    rstn = 1'b1;
    tick(5);
    send(8'h1C, 0, 11, 4'b1000);

    tick(20);
    chk("scoreboard_drained", 8'(expq.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_move_decoder.md
PS2_MOVE_DECODER -- requirements
Module: ps2_move_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000, meaning the maximum number of CLOCK_50 cycles between PS/2 clock falling edges inside a frame (1 ms).
REQ-002 SHALL have port CLOCK_50  input  1  system clock, 50 MHz.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low; clock CLOCK_50.
REQ-004 SHALL have port PS2_CLK  input  1  keyboard clock, asynchronous, idle high.
REQ-005 SHALL have port PS2_DAT  input  1  keyboard data, asynchronous, idle high.
REQ-006 SHALL have port key_pressed  output  4  one-cycle move pulses: [3] turn left, [2] turn right, [1] forward, [0] backward; feeds player key_pressed.
REQ-007 SHALL have port byte_valid  output  1  one-cycle pulse, good frame received.
REQ-008 SHALL have port rx_byte  output  8  last good scan byte, held until the next good frame.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-010 SHALL pass PS2_CLK and PS2_DAT through 2-flop synchronizers and detect a falling edge of the synchronized clock as prev=1, cur=0.
REQ-011 SHALL implement receiver states IDLE, DATA, PARITY, STOP; all samples SHALL be taken from synchronized PS2_DAT on a detected falling edge.
REQ-012 SHALL, in IDLE, go to DATA on a falling edge with data 0 (start bit); a start bit with data 1 SHALL be ignored and the block SHALL stay in IDLE.
REQ-013 SHALL, in DATA, shift in 8 bits LSB first (bit counter 0..7), then go to PARITY.
REQ-014 SHALL, in PARITY, capture the parity bit and go to STOP.
REQ-015 SHALL, in STOP, return to IDLE on the falling edge; a good frame requires stop bit = 1 and odd parity over the 8 data bits plus the parity bit.
REQ-016 SHALL, for a good frame whose stop edge is detected in cycle N, assert byte_valid and update rx_byte in cycle N+1.
REQ-017 SHALL, for a bad frame whose stop edge is detected in cycle N, pulse frame_err in cycle N+1, with no byte_valid and no change to rx_byte.
REQ-018 SHALL keep a timeout counter that clears on every falling edge and counts in every non-IDLE state.
REQ-019 SHALL, when the timeout counter reaches TIMEOUT-1, pulse frame_err, return to IDLE and discard partial data.
REQ-020 SHALL, in the decoder, set the brk flag on byte 0xF0 and the ext flag on byte 0xE0, with no pulse for either byte.
REQ-021 SHALL, on any other good byte, act using the current flags and then clear both flags.
REQ-022 SHALL use this mapping with ext=0: 0x1D->bit1 (W), 0x1B->bit0 (S), 0x1C->bit3 (A), 0x23->bit2 (D).
REQ-023 SHALL use this mapping with ext=1: 0x75->bit1 (up arrow), 0x72->bit0 (down arrow), 0x6B->bit3 (left arrow), 0x74->bit2 (right arrow).
REQ-024 SHALL ignore unmapped codes and codes with ext mismatched to the tables (the flags are still cleared).
REQ-025 SHALL keep a 4-bit held vector; a make of mapped bit k with held[k]=0 SHALL set held[k] and pulse key_pressed[k] one cycle after byte_valid (cycle N+2).
REQ-026 SHALL suppress the pulse on a make with held[k]=1 (typematic repeat).
REQ-027 SHALL, on a break (brk=1) of mapped bit k, clear held[k] with no pulse.
REQ-028 SHALL share held[k] between a letter key and its arrow key, so a second make of either key while one is held produces no pulse.
REQ-029 SHALL guarantee key_pressed is at most one-hot, and SHALL keep it high for exactly one cycle per qualifying make.
REQ-030 SHALL NOT stall or drop the next frame because of decoding; decoding SHALL finish within 1 cycle of byte_valid.

Reset
REQ-031 SHALL, while rstn=0 at a CLOCK_50 edge, force the state to IDLE and clear the bit counter, timeout counter, brk, ext and held.
REQ-032 SHALL, while rstn=0 at a CLOCK_50 edge, drive key_pressed=0, byte_valid=0, frame_err=0 and rx_byte=0x00; the synchronizer flops SHALL reset to 1.
REQ-033 SHALL, on reset mid-frame, discard the partial frame with no pulses; the next start bit after rstn=1 SHALL begin a fresh frame.

Verification
REQ-034 SHALL be tested with: frame 0x1D (parity 1) -> byte_valid with rx_byte=0x1D, then key_pressed=4'b0010 for one cycle.
REQ-035 SHALL be tested with: 0x1D, 0x1D, 0x1D -> exactly one pulse; then F0 1D, 1D -> one further 4'b0010 pulse.
REQ-036 SHALL be tested with: E0 6B -> key_pressed=4'b1000; then E0 F0 6B -> held[3] cleared with no pulse.
REQ-037 SHALL be tested with: frame 0x23 with the parity bit flipped -> frame_err pulse, no byte_valid, rx_byte unchanged, no key_pressed.
REQ-038 SHALL be tested with: start bit plus 4 data bits, then PS2_CLK held high for TIMEOUT cycles -> frame_err, state IDLE; a following 0x1B frame -> 4'b0001.
REQ-039 SHALL be tested with: rstn=0 after the 6th falling edge of a frame -> all outputs 0; a clean 0x1C frame after release -> 4'b1000.
